// File: rtl/rggen_irq_event_capture_if.sv
// rggen_irq_event_capture_if: event, W1C/W1S strobes and status outputs of the interrupt capture block
interface rggen_irq_event_capture_if #(
    parameter int TOTAL_INTERRUPTS = 1
);
    logic [TOTAL_INTERRUPTS-1:0] i_event;
    logic                        i_clear_valid;
    logic [TOTAL_INTERRUPTS-1:0] i_clear_mask;
    logic                        i_set_valid;
    logic [TOTAL_INTERRUPTS-1:0] i_set_mask;
    logic [TOTAL_INTERRUPTS-1:0] o_isr;
    logic [TOTAL_INTERRUPTS-1:0] o_overflow;
    logic                        o_pending;
    modport master (
        output i_event, i_clear_valid, i_clear_mask, i_set_valid, i_set_mask,
        input  o_isr, o_overflow, o_pending
    );
    modport slave (
        input  i_event, i_clear_valid, i_clear_mask, i_set_valid, i_set_mask,
        output o_isr, o_overflow, o_pending
    );
endinterface

// File: rtl/rggen_irq_event_capture.sv
// rggen_irq_event_capture: sticky per-source ISR bits with W1C/W1S and edge-mode overflow flags
module rggen_irq_event_capture #(
    parameter int                          TOTAL_INTERRUPTS = 1,
    parameter logic [TOTAL_INTERRUPTS-1:0] EDGE_MODE        = '0,
    parameter bit                          ENABLE_OVERFLOW  = 1'b1
) (
    input logic                    clk,
    input logic                    rst_n,
    rggen_irq_event_capture_if.slave bus
);
    logic [TOTAL_INTERRUPTS-1:0] event_q;
    logic [TOTAL_INTERRUPTS-1:0] isr;
    logic [TOTAL_INTERRUPTS-1:0] ovf;
    logic [TOTAL_INTERRUPTS-1:0] hit;
    logic [TOTAL_INTERRUPTS-1:0] set;
    logic [TOTAL_INTERRUPTS-1:0] clr;
    logic [TOTAL_INTERRUPTS-1:0] ovf_next;
    always_comb begin
        hit      = bus.i_event & (~EDGE_MODE | ~event_q);
        set      = hit | ({TOTAL_INTERRUPTS{bus.i_set_valid}} & bus.i_set_mask);
        clr      = {TOTAL_INTERRUPTS{bus.i_clear_valid}} & bus.i_clear_mask;
        // a hit coinciding with a clear is a fresh capture, never an overflow
        ovf_next = ENABLE_OVERFLOW ? EDGE_MODE & ~clr & ((hit & isr) | ovf) : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_q <= '0;
            isr     <= '0;
            ovf     <= '0;
        end else begin
            event_q <= bus.i_event;
            isr     <= set | (isr & ~clr);
            ovf     <= ovf_next;
        end
    end
    assign bus.o_isr      = isr;
    assign bus.o_overflow = ovf;
    assign bus.o_pending  = |isr;
endmodule

// File: tb/tb_rggen_irq_event_capture.sv
// tb_rggen_irq_event_capture: directed scenarios plus random traffic against a per-bit behavioural model
module tb_rggen_irq_event_capture;
    localparam int         N    = 4;
    localparam logic [3:0] EDGE = 4'b0101;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [N-1:0] m_isr, m_ovf, m_prev;
    rggen_irq_event_capture_if #(.TOTAL_INTERRUPTS(N)) bus ();
    rggen_irq_event_capture #(
        .TOTAL_INTERRUPTS(N),
        .EDGE_MODE       (EDGE),
        .ENABLE_OVERFLOW (1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // reference: each source judged independently from its own previous input
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_isr  = '0;
            m_ovf  = '0;
            m_prev = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                bit h, s, c;
                h = EDGE[i] ? (bus.i_event[i] && !m_prev[i]) : bus.i_event[i];
                s = h || (bus.i_set_valid && bus.i_set_mask[i]);
                c = bus.i_clear_valid && bus.i_clear_mask[i];
                if (EDGE[i] && h && m_isr[i] && !c) m_ovf[i] = 1'b1;
                else if (c) m_ovf[i] = 1'b0;
                if (s) m_isr[i] = 1'b1;
                else if (c) m_isr[i] = 1'b0;
            end
            m_prev = bus.i_event;
        end
    end
    always @(negedge clk) begin
        check("isr_vs_model", bus.o_isr, m_isr);
        check("ovf_vs_model", bus.o_overflow, m_ovf);
        check("pending_vs_model", {3'b0, bus.o_pending}, {3'b0, |m_isr});
    end
    task automatic drv(input logic [N-1:0] ev, input logic cv, input logic [N-1:0] cm,
                       input logic sv, input logic [N-1:0] sm);
        bus.i_event = ev;
        bus.i_clear_valid = cv;
        bus.i_clear_mask = cm;
        bus.i_set_valid = sv;
        bus.i_set_mask = sm;
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    initial begin
        drv(4'hF, 1'b0, '0, 1'b0, '0);
        repeat (3) cyc();
        check("reset_isr", bus.o_isr, 4'h0);
        check("reset_ovf", bus.o_overflow, 4'h0);
        check("reset_pending", {3'b0, bus.o_pending}, 4'h0);
        rst_n = 1'b1;
        cyc();
        check("release_isr", bus.o_isr, 4'hF);
        check("release_model_isr", m_isr, 4'hF);
        drv(4'h0, 1'b1, 4'hF, 1'b0, '0);
        cyc();
        check("clear_all", bus.o_isr, 4'h0);
        drv(4'h1, 1'b0, '0, 1'b0, '0);
        cyc();
        check("edge_isr", bus.o_isr, 4'h1);
        check("edge_pending", {3'b0, bus.o_pending}, 4'h1);
        drv(4'h0, 1'b0, '0, 1'b0, '0);
        cyc();
        check("edge_sticky", bus.o_isr, 4'h1);
        drv(4'h0, 1'b1, 4'h1, 1'b0, '0);
        cyc();
        check("edge_clear", bus.o_isr, 4'h0);
        drv(4'h1, 1'b0, '0, 1'b0, '0);
        cyc();
        drv(4'h0, 1'b0, '0, 1'b0, '0);
        cyc();
        drv(4'h1, 1'b1, 4'h1, 1'b0, '0);
        cyc();
        check("collide_isr", bus.o_isr, 4'h1);
        check("collide_ovf", bus.o_overflow, 4'h0);
        drv(4'h0, 1'b0, '0, 1'b0, '0);
        cyc();
        drv(4'h1, 1'b0, '0, 1'b0, '0);
        cyc();
        check("ovf_set", bus.o_overflow, 4'h1);
        check("ovf_model", m_ovf, 4'h1);
        drv(4'h0, 1'b1, 4'h1, 1'b0, '0);
        cyc();
        check("ovf_clear_isr", bus.o_isr, 4'h0);
        check("ovf_clear_ovf", bus.o_overflow, 4'h0);
        drv(4'h2, 1'b0, '0, 1'b0, '0);
        cyc();
        check("level_isr", bus.o_isr, 4'h2);
        drv(4'h2, 1'b1, 4'h2, 1'b0, '0);
        cyc();
        check("level_clear_held", bus.o_isr, 4'h2);
        drv(4'h0, 1'b0, '0, 1'b0, '0);
        cyc();
        check("level_sticky", bus.o_isr, 4'h2);
        drv(4'h0, 1'b1, 4'h2, 1'b0, '0);
        cyc();
        check("level_clear", bus.o_isr, 4'h0);
        check("level_ovf", bus.o_overflow, 4'h0);
        drv(4'h0, 1'b1, 4'h0, 1'b0, 4'hF);
        cyc();
        check("strobe_no_mask", bus.o_isr, 4'h0);
        drv(4'h0, 1'b0, '0, 1'b1, 4'hA);
        cyc();
        check("w1s_isr", bus.o_isr, 4'hA);
        check("w1s_ovf", bus.o_overflow, 4'h0);
        drv(4'h0, 1'b0, '0, 1'b0, '0);
        #2 rst_n = 1'b0;
        #1;
        check("async_isr", bus.o_isr, 4'h0);
        check("async_pending", {3'b0, bus.o_pending}, 4'h0);
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 400; k++) begin
            drv(N'($urandom), ($urandom_range(0, 3) == 0), N'($urandom),
                ($urandom_range(0, 7) == 0), N'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                #1 check("rand_async_isr", bus.o_isr, 4'h0);
                #1 rst_n = 1'b1;
            end
            cyc();
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
